// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store front-end to a 1-cycle-latency RAM
// with error flagging for out-of-range addresses and saturating op counters.
module mem_access_ctrl #(
  parameter int addr_size = 8,
  parameter int data_size = 8,
  parameter int mem_depth = 256,
  parameter int cnt_size  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [addr_size-1:0] req_addr,
  input  logic [data_size-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_we,
  output logic                 resp_err,
  output logic [data_size-1:0] resp_rdata,
  output logic                 ram_write_en,
  output logic [addr_size-1:0] ram_write_adress,
  output logic [data_size-1:0] ram_data_in,
  output logic                 ram_rd_en,
  output logic [addr_size-1:0] ram_rd_adress,
  input  logic [data_size-1:0] ram_data_out,
  output logic [cnt_size-1:0]  rd_count,
  output logic [cnt_size-1:0]  wr_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  localparam logic [addr_size:0] depth_c = (addr_size+1)'(mem_depth);
  state_t state_q;
  logic   we_q;
  logic   in_range;
  assign in_range  = {1'b0, req_addr} < depth_c;
  assign req_ready = state_q == IDLE;
  // Enables are raised at the accept edge so they are high for exactly the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      resp_valid       <= 1'b0;
      resp_we          <= 1'b0;
      resp_err         <= 1'b0;
      resp_rdata       <= '0;
      ram_write_en     <= 1'b0;
      ram_write_adress <= '0;
      ram_data_in      <= '0;
      ram_rd_en        <= 1'b0;
      ram_rd_adress    <= '0;
      rd_count         <= '0;
      wr_count         <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q       <= req_we;
          resp_we    <= req_we;
          resp_err   <= !in_range;
          resp_rdata <= '0;
          if (in_range) begin
            ram_write_en <= req_we;
            ram_rd_en    <= !req_we;
            if (req_we) begin
              ram_write_adress <= req_addr;
              ram_data_in      <= req_wdata;
            end else ram_rd_adress <= req_addr;
            state_q <= ISSUE;
          end else begin
            resp_valid <= 1'b1;
            state_q    <= RESP;
          end
        end
        ISSUE: begin
          ram_write_en <= 1'b0;
          ram_rd_en    <= 1'b0;
          resp_valid   <= we_q;
          state_q      <= we_q ? RESP : CAPTURE;
        end
        CAPTURE: begin
          resp_rdata <= ram_data_out;
          resp_valid <= 1'b1;
          state_q    <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state_q    <= IDLE;
          if (!resp_err && resp_we && wr_count != '1) wr_count <= wr_count + cnt_size'(1);
          if (!resp_err && !resp_we && rd_count != '1) rd_count <= rd_count + cnt_size'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized transactions against a memory/counter
// reference model, with a behavioural 1-cycle-latency RAM attached to the DUT.
module tb_mem_access_ctrl;
  localparam int AW = 8, DW = 8, DEPTH = 128, CW = 2, CMAX = 3;
  logic          clk = 1'b0, rst;
  logic          req_valid, req_ready, req_we, resp_valid, resp_ready, resp_we, resp_err;
  logic [AW-1:0] req_addr, ram_write_adress, ram_rd_adress;
  logic [DW-1:0] req_wdata, resp_rdata, ram_data_in, ram_data_out;
  logic          ram_write_en, ram_rd_en;
  logic [CW-1:0] rd_count, wr_count;
  logic [DW-1:0] ram   [256] = '{default: 8'h00};
  logic [DW-1:0] mem_m [256] = '{default: 8'h00};
  int checks = 0, failures = 0, rd_m = 0, wr_m = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.addr_size(AW), .data_size(DW), .mem_depth(DEPTH), .cnt_size(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_we(resp_we), .resp_err(resp_err), .resp_rdata(resp_rdata), .ram_write_en(ram_write_en),
    .ram_write_adress(ram_write_adress), .ram_data_in(ram_data_in), .ram_rd_en(ram_rd_en),
    .ram_rd_adress(ram_rd_adress), .ram_data_out(ram_data_out), .rd_count(rd_count),
    .wr_count(wr_count));

  always @(posedge clk) begin
    if (ram_write_en) ram[ram_write_adress] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= ram[ram_rd_adress];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic present(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic check_counts();
    chk("rd_count", rd_count, rd_m);
    chk("wr_count", wr_count, wr_m);
  endtask

  // One transaction from accept to handshake; optionally presents the next request while held.
  task automatic txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold,
                     input bit pre, input logic nwe, input logic [AW-1:0] na, input logic [DW-1:0] nd);
    int lat = 0, nw = 0, nr = 0;
    bit err = a >= DEPTH;
    logic [DW-1:0] exp_d = (we || err) ? '0 : mem_m[a];
    present(we, a, d);
    resp_ready = 1'b0;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    idle_req();
    for (int k = 1; k <= 6; k++) begin
      chk("one_enable", ram_write_en & ram_rd_en, 0);
      if (ram_write_en) begin
        nw++;
        chk("wr_addr", ram_write_adress, a);
        chk("wr_data", ram_data_in, d);
      end
      if (ram_rd_en) begin
        nr++;
        chk("rd_addr", ram_rd_adress, a);
      end
      if (resp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk("latency", lat, err ? 1 : we ? 2 : 3);
    chk("wr_pulses", nw, 32'(we && !err));
    chk("rd_pulses", nr, 32'(!we && !err));
    for (int h = 0; h <= hold; h++) begin
      if (pre) present(nwe, na, nd);
      chk("resp_valid_hold", resp_valid, 1);
      chk("req_ready_busy", req_ready, 0);
      chk("resp_we", resp_we, we);
      chk("resp_err", resp_err, err);
      chk("resp_rdata", resp_rdata, exp_d);
      chk("en_quiet", {ram_write_en, ram_rd_en}, 0);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (!pre) idle_req();
    if (!err && we) begin
      mem_m[a] = d;
      wr_m = (wr_m < CMAX) ? wr_m + 1 : CMAX;
    end
    if (!err && !we) rd_m = (rd_m < CMAX) ? rd_m + 1 : CMAX;
    chk("resp_valid_drop", resp_valid, 0);
    check_counts();
  endtask

  initial begin
    logic          cwe, nwe;
    logic [AW-1:0] ca, na;
    logic [DW-1:0] cd, nd;
    rst = 1'b1;
    resp_ready = 1'b0;
    idle_req();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_enables", {ram_write_en, ram_rd_en}, 0);
    chk("rst_resp_bits", {resp_we, resp_err, resp_rdata}, 0);
    check_counts();
    rst = 1'b0;
    // reset landing in CAPTURE of a load drops it
    present(1'b0, 8'h20, 8'h00);
    @(posedge clk); #1;
    idle_req();
    chk("issue_rd_en", ram_rd_en, 1);
    @(posedge clk); #1;
    chk("capture_rd_en", ram_rd_en, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_enables", {ram_write_en, ram_rd_en}, 0);
    repeat (3) begin
      chk("mid_rst_no_resp", resp_valid, 0);
      @(posedge clk); #1;
    end
    check_counts();
    txn(1'b1, 8'h10, 8'hA5, 0, 0, 0, 0, 0);
    txn(1'b0, 8'h10, 8'h00, 0, 0, 0, 0, 0);
    txn(1'b0, 8'h80, 8'h00, 1, 0, 0, 0, 0);
    txn(1'b1, 8'h7F, 8'h3C, 0, 0, 0, 0, 0);
    txn(1'b0, 8'h7F, 8'h00, 0, 0, 0, 0, 0);
    txn(1'b1, 8'hFF, 8'h99, 0, 0, 0, 0, 0);
    // back-pressure with the next request held valid the whole time
    txn(1'b0, 8'h10, 8'h00, 5, 1, 1'b1, 8'h22, 8'h5C);
    txn(1'b1, 8'h22, 8'h5C, 0, 0, 0, 0, 0);
    txn(1'b0, 8'h22, 8'h00, 0, 0, 0, 0, 0);
    cwe = 1'($urandom);
    ca  = AW'($urandom);
    cd  = DW'($urandom);
    for (int i = 0; i < 60; i++) begin
      nwe = 1'($urandom);
      na  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(DEPTH, 255)) : AW'($urandom_range(0, 15));
      nd  = DW'($urandom);
      txn(cwe, ca, cd, $urandom_range(0, 3), 1'($urandom), nwe, na, nd);
      cwe = nwe;
      ca  = na;
      cd  = nd;
    end
    idle_req();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_m = 0;
    wr_m = 0;
    check_counts();
    for (int i = 0; i < 4; i++) txn(1'b1, AW'(i), DW'($urandom), 0, 0, 0, 0, 0);
    chk("wr_saturated", wr_count, CMAX);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
